shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with Start.
REQ-006 Port: Multiplicand  input  WIDTH  operand S; latched with Start.
REQ-007 Port: Multiplier  input  WIDTH  operand M; latched with Start.
REQ-008 Port: Busy  output  1  high in CALC and DONE states.
REQ-009 Port: Done  output  1  one-cycle pulse; Product valid.
REQ-010 Port: Product  output  2*WIDTH  {A,B} result register.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
  - IDLE -> CALC on Start=1.
  - CALC -> DONE when step counter = WIDTH-1.
  - DONE -> IDLE unconditionally.
REQ-012 On the edge accepting Start, the block SHALL:
  - load B <= Multiplier, S <= Multiplicand, mode <= Signed_Mode;
  - clear A and X;
  - clear step counter (width $clog2(WIDTH)).
REQ-013 Each CALC cycle SHALL perform one combined add and shift:
  - if B[0]=1, form the (WIDTH+1)-bit sum {X',A'} = A +/- S, else {X',A'} = {X,A};
  - then {X,A,B} <= {X',X',A',B} >> 1, keeping the top bit as X';
  - increment the counter.
REQ-014 In signed mode, the step with counter = WIDTH-1 SHALL subtract S when B[0]=1; all other steps SHALL add.
  - X' = sign bit of the sign-extended WIDTH+1 result.
REQ-015 In unsigned mode, all steps SHALL add, and X' = carry-out of the unsigned WIDTH-bit addition.
REQ-016 Product SHALL equal the exact 2*WIDTH-bit product (signed or unsigned per latched mode) when Done=1.
  - Product SHALL hold its value until the next accepted Start.
REQ-017 Done SHALL be high for exactly one cycle, WIDTH+1 rising edges after the edge that accepted Start.
  - Total latency: WIDTH+1 cycles.
REQ-018 Start in CALC or DONE SHALL be ignored.
  - A Start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-019 Operand or Signed_Mode changes after acceptance SHALL NOT affect the running operation.
REQ-020 Product SHALL change only on the accepting edge and on CALC edges; Product[WIDTH-1:0] tracks B and Product[2*WIDTH-1:WIDTH] tracks A.

Reset
REQ-021 Reset=1 at a rising edge SHALL force the following, regardless of state, including mid-CALC:
  - state IDLE;
  - A, B, S, X, counter and mode to 0;
  - Busy=0, Done=0, Product=0.
REQ-022 Reset SHALL take priority over Start on the same edge.

Structure
REQ-023 Shared package mult_pkg SHALL hold the state enum typedef (mult_state_t) and the WIDTH legal-range constants.
REQ-024 One sub-module, addsub_w, SHALL implement the WIDTH+1-bit add/subtract with signed/unsigned extension.
  - It is parameterised by WIDTH and is purely combinational.
REQ-025 An elaboration-time check SHALL reject WIDTH outside 2..32.

Verification
REQ-026 WIDTH=8, unsigned, S=0xFF, M=0xFF:
  - Product=0xFE01;
  - Done high exactly 9 cycles after the Start edge;
  - Busy high for the 9 intervening cycles.
REQ-027 WIDTH=8, signed, four cases:
  - S=0xFF, M=0xFF -> Product=0x0001;
  - S=0x80, M=0x80 -> 0x4000;
  - S=0x07, M=0xFD -> 0xFFEB;
  - S=0x80, M=0x7F -> 0xC080.
REQ-028 Start pulsed again at cycle 3 of a running op with different operands:
  - the pulse is ignored;
  - the first result is unchanged;
  - Done pulses exactly once.
REQ-029 Reset asserted at CALC cycle 4:
  - next cycle Busy=0, Done=0, Product=0x0000;
  - a subsequent Start (S=0x03, M=0x05, unsigned) -> Product=0x000F.
REQ-030 Start held high continuously:
  - back-to-back operations accepted every WIDTH+2 cycles;
  - each Done is a single-cycle pulse.
REQ-031 WIDTH=16, unsigned, S=0xFFFF, M=0x0002:
  - Product=0x0001FFFE;
  - Done 17 cycles after the Start edge.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

    // Controller states: waiting, iterating one bit per cycle, result ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Legal operand width range
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/shift_add_mult_addsub_w.sv
// WIDTH+1-bit adder/subtractor; operands are sign- or zero-extended by one bit.
// In unsigned mode the top result bit is the carry-out; in signed mode it is
// the sign of the extended result.
module addsub_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_signed,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    assign w_a_ext = {i_signed & i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_signed & i_b[WIDTH-1], i_b};

    // Single combined add or subtract in extended width
    always_comb begin
        o_sum = '0;
        if (i_sub) begin
            o_sum = w_a_ext - w_b_ext;
        end else begin
            o_sum = w_a_ext + w_b_ext;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Partial product lives in {X,A}; the multiplier B is shifted out from the
// bottom while result bits are shifted in from A, so {A,B} ends as the product.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject unsupported widths at elaboration
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("shift_add_mult: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    mult_state_t      r_state;
    mult_state_t      w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_x;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_done;

    logic             w_last;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_step;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    // Signed operands: the multiplier's top bit has negative weight
    assign w_sub  = r_mode & w_last & r_b[0];

    addsub_w #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a      (r_a),
        .i_b      (r_s),
        .i_sub    (w_sub),
        .i_signed (r_mode),
        .o_sum    (w_sum)
    );

    // Select the step result; an unsigned step without an add has no carry,
    // so X must not re-inject a carry from an earlier step
    always_comb begin
        w_step = {r_x & r_mode, r_a};
        if (r_b[0]) begin
            w_step = w_sum;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (Start) w_state_next = ST_CALC;
            ST_CALC: if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        Busy    = (r_state == ST_CALC) || (r_state == ST_DONE);
        Done    = r_done;
        Product = {r_a, r_b};
    end

    // Datapath: operand capture on accept, one add-and-shift per CALC cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_x    <= 1'b0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_b    <= Multiplier;
                        r_s    <= Multiplicand;
                        r_mode <= Signed_Mode;
                        r_a    <= '0;
                        r_x    <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                ST_CALC: begin
                    r_x   <= w_step[WIDTH];
                    r_a   <= w_step[WIDTH:1];
                    r_b   <= {w_step[0], r_b[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at WIDTH=8 and WIDTH=16.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] prod;

    logic        start16;
    logic [15:0] mc16;
    logic [15:0] mp16;
    logic        busy16;
    logic        done16;
    logic [31:0] prod16;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(8)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .Start        (start),
        .Signed_Mode  (sgn),
        .Multiplicand (mcand),
        .Multiplier   (mplier),
        .Busy         (busy),
        .Done         (done),
        .Product      (prod)
    );

    shift_add_mult #(.WIDTH(16)) dut16 (
        .Clk          (clk),
        .Reset        (rst),
        .Start        (start16),
        .Signed_Mode  (1'b0),
        .Multiplicand (mc16),
        .Multiplier   (mp16),
        .Busy         (busy16),
        .Done         (done16),
        .Product      (prod16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 60) begin
            tick();
            n++;
        end
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL %s idle_wait busy=%b done=%b expected 0/0", name, busy, done);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; sgn = 1'b0; mcand = 8'h00; mplier = 8'h00;
        start16 = 1'b0; mc16 = 16'h0; mp16 = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else pass_cnt++;
        total_cnt++;
        if (prod !== 16'h0000) $display("FAIL reset_product got %h expected 0000", prod); else pass_cnt++;
        total_cnt++;
        if (prod16 !== 32'h0 || busy16 !== 1'b0)
            $display("FAIL reset_w16 got prod=%h busy=%b expected 0/0", prod16, busy16);
        else pass_cnt++;
        $display("reset: busy=%b done=%b product=%h", busy, done, prod);
    endtask

    // One operation with operands scrambled after acceptance
    task automatic run_op(input logic s_mode, input logic [7:0] s, input logic [7:0] m,
                          input logic [15:0] expv, input string name);
        int busy_cnt, done_cnt, done_at;
        logic done_busy;
        logic [15:0] prod_at;
        wait_idle(name);
        sgn = s_mode; mcand = s; mplier = m; start = 1'b1;
        tick();
        start = 1'b0; sgn = ~s_mode; mcand = ~s; mplier = ~m;
        busy_cnt  = (busy === 1'b1) ? 1 : 0;
        done_cnt  = 0;
        done_at   = -1;
        done_busy = 1'b0;
        prod_at   = 16'h0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k; prod_at = prod; done_busy = busy;
                end
            end
        end
        total_cnt++;
        if (prod_at !== expv) $display("FAIL %s product got %h expected %h", name, prod_at, expv); else pass_cnt++;
        total_cnt++;
        if (done_at != 9) $display("FAIL %s latency got %0d expected 9", name, done_at); else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL %s done_pulses got %0d expected 1", name, done_cnt); else pass_cnt++;
        total_cnt++;
        if (busy_cnt != 9) $display("FAIL %s busy_cycles got %0d expected 9", name, busy_cnt); else pass_cnt++;
        total_cnt++;
        if (done_busy !== 1'b0) $display("FAIL %s busy_at_done got %b expected 0", name, done_busy); else pass_cnt++;
        total_cnt++;
        if (prod !== expv) $display("FAIL %s product_hold got %h expected %h", name, prod, expv); else pass_cnt++;
        $display("op %s: mode=%b S=%h M=%h product=%h latency=%0d", name, s_mode, s, m, prod_at, done_at);
    endtask

    task automatic test_unsigned();
        run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff");
        run_op(1'b0, 8'h03, 8'h05, 16'h000F, "u_03_05");
        run_op(1'b0, 8'h00, 8'hA5, 16'h0000, "u_00_a5");
    endtask

    task automatic test_signed();
        run_op(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ff_ff");
        run_op(1'b1, 8'h80, 8'h80, 16'h4000, "s_80_80");
        run_op(1'b1, 8'h07, 8'hFD, 16'hFFEB, "s_07_fd");
        run_op(1'b1, 8'h80, 8'h7F, 16'hC080, "s_80_7f");
    endtask

    task automatic test_start_ignored();
        int done_cnt, done_at;
        logic [15:0] prod_at;
        wait_idle("start_ign");
        sgn = 1'b0; mcand = 8'h0C; mplier = 8'h0B; start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0; done_at = -1; prod_at = 16'h0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                start = 1'b1; mcand = 8'h55; mplier = 8'h33;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k; prod_at = prod;
                end
            end
        end
        total_cnt++;
        if (prod_at !== 16'h0084) $display("FAIL start_ign product got %h expected 0084", prod_at); else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL start_ign done_pulses got %0d expected 1", done_cnt); else pass_cnt++;
        total_cnt++;
        if (done_at != 9) $display("FAIL start_ign latency got %0d expected 9", done_at); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || prod !== 16'h0084)
            $display("FAIL start_ign after got busy=%b prod=%h expected 0/0084", busy, prod);
        else pass_cnt++;
        $display("start_ignored: product=%h done_pulses=%0d latency=%0d", prod_at, done_cnt, done_at);
    endtask

    task automatic test_reset_mid();
        wait_idle("reset_mid");
        sgn = 1'b0; mcand = 8'hFF; mplier = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_mid busy got %b expected 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_mid done got %b expected 0", done); else pass_cnt++;
        total_cnt++;
        if (prod !== 16'h0000) $display("FAIL reset_mid product got %h expected 0000", prod); else pass_cnt++;
        $display("reset_mid: busy=%b done=%b product=%h", busy, done, prod);
        run_op(1'b0, 8'h03, 8'h05, 16'h000F, "after_reset");
    endtask

    task automatic test_reset_priority();
        wait_idle("rst_prio");
        rst = 1'b1; start = 1'b1; sgn = 1'b0; mcand = 8'h11; mplier = 8'h22;
        tick();
        rst = 1'b0; start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || prod !== 16'h0000)
            $display("FAIL rst_prio got busy=%b prod=%h expected 0/0000", busy, prod);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_prio_after busy got %b expected 0", busy); else pass_cnt++;
        $display("reset_priority: busy=%b product=%h", busy, prod);
    endtask

    task automatic test_back_to_back();
        int pulses, first_at, last_at, bad_prod, wide, gap_bad, prev_at;
        logic prev_done;
        wait_idle("b2b");
        sgn = 1'b0; mcand = 8'h03; mplier = 8'h05; start = 1'b1;
        pulses = 0; first_at = -1; last_at = -1; bad_prod = 0; wide = 0; gap_bad = 0;
        prev_at = -1; prev_done = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k;
                last_at = k;
                if (prod !== 16'h000F) bad_prod++;
                if (prev_done) wide++;
                if (prev_at >= 0 && (k - prev_at) != 10) gap_bad++;
                prev_at = k;
            end
            prev_done = done;
        end
        start = 1'b0;
        total_cnt++;
        if (pulses != 4) $display("FAIL b2b pulses got %0d expected 4", pulses); else pass_cnt++;
        total_cnt++;
        if (first_at != 10 || last_at != 40)
            $display("FAIL b2b timing got first=%0d last=%0d expected 10/40", first_at, last_at);
        else pass_cnt++;
        total_cnt++;
        if (gap_bad != 0) $display("FAIL b2b period bad_gaps=%0d expected 0", gap_bad); else pass_cnt++;
        total_cnt++;
        if (wide != 0) $display("FAIL b2b pulse_width wide=%0d expected 0", wide); else pass_cnt++;
        total_cnt++;
        if (bad_prod != 0) $display("FAIL b2b product bad=%0d expected 0", bad_prod); else pass_cnt++;
        $display("back_to_back: pulses=%0d first=%0d last=%0d", pulses, first_at, last_at);
        wait_idle("b2b_drain");
    endtask

    task automatic test_width16();
        int done_cnt, done_at;
        logic [31:0] prod_at;
        mc16 = 16'hFFFF; mp16 = 16'h0002; start16 = 1'b1;
        tick();
        start16 = 1'b0; mc16 = 16'h1234; mp16 = 16'h5678;
        done_cnt = 0; done_at = -1; prod_at = 32'h0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (done16 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k; prod_at = prod16;
                end
            end
        end
        total_cnt++;
        if (prod_at !== 32'h0001FFFE) $display("FAIL w16 product got %h expected 0001fffe", prod_at); else pass_cnt++;
        total_cnt++;
        if (done_at != 17) $display("FAIL w16 latency got %0d expected 17", done_at); else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL w16 done_pulses got %0d expected 1", done_cnt); else pass_cnt++;
        $display("w16: product=%h latency=%0d", prod_at, done_at);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        test_reset_priority();
        test_back_to_back();
        test_width16();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
